input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 184 ++++++++++++++++++
 tb/tb_input_debouncer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Multi-channel button/switch conditioner. Each channel runs the raw level
// through a two-flop synchroniser and a stable-time debounce filter, then
// emits one-cycle press/release strobes. A per-channel repeat FSM adds
// auto-repeat strobes while a button is held.
//
// Ports
//   clk           : sole clock
//   reset         : asynchronous, active-low reset
//   raw_in        : asynchronous raw levels, one bit per channel
//   level_out     : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe in the first cycle level_out shows 1
//   release_pulse : one-cycle strobe in the first cycle level_out shows 0
//   repeat_pulse  : one-cycle auto-repeat strobe while held
//   move_pulse    : press_pulse | repeat_pulse
// ---------------------------------------------------------------------------
module input_debouncer #(
   parameter int              N_CH            = 5,
   parameter int              DEBOUNCE_CYCLES = 1000000,
   parameter int              REPEAT_DELAY    = 50000000,
   parameter int              REPEAT_PERIOD   = 10000000,
   parameter logic [N_CH-1:0] REPEAT_EN       = {N_CH{1'b1}},
   parameter bit              ACTIVE_LOW_IN   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] repeat_pulse,
   output logic [N_CH-1:0] move_pulse
);

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_WAIT   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   localparam int               DB_W        = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int               HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                              : REPEAT_PERIOD;
   localparam int               HOLD_W      = $clog2(HOLD_MAX) + 1;
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   // ------------------------------------------------------------------------
   // Two-flop synchroniser, polarity normalised so that 1 = pressed.
   // ------------------------------------------------------------------------
   logic [N_CH-1:0] sync1_q, sync1_d;
   logic [N_CH-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = raw_in ^ {N_CH{ACTIVE_LOW_IN}};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // ------------------------------------------------------------------------
   // Per-channel debounce filter and repeat FSM.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic              level_q, level_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              repeat_q, repeat_d;
      logic              move_q, move_d;
      logic              flip;
      rpt_state_e        state_q, state_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

      // Debounce: count consecutive cycles where the synchronised input
      // disagrees with the accepted level; any agreement restarts the count.
      always_comb begin
         // NOTE: every comb output gets a default first so no path through
         // the block leaves it unassigned (which would infer a latch).
         flip     = 1'b0;
         db_cnt_d = '0;
         if (sync2_q[i] != level_q) begin
            if (db_cnt_q == DB_LAST) begin
               flip = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         level_d   = level_q ^ flip;
         press_d   = flip & ~level_q;
         release_d = flip & level_q;
      end

      // Repeat FSM next state. The hold counter only runs in WAIT/REPEAT and
      // is cleared at every terminal count, so it can never wrap.
      always_comb begin
         state_d    = state_q;
         hold_cnt_d = hold_cnt_q + 1'b1;
         case (state_q)
            RPT_IDLE: begin
               hold_cnt_d = '0;
               if (press_d && REPEAT_EN[i]) begin
                  state_d = RPT_WAIT;
               end
            end
            RPT_WAIT: begin
               if (release_d) begin
                  state_d    = RPT_IDLE;
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == DELAY_LAST) begin
                  state_d    = RPT_REPEAT;
                  hold_cnt_d = '0;
               end
            end
            RPT_REPEAT: begin
               if (release_d) begin
                  state_d    = RPT_IDLE;
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == PERIOD_LAST) begin
                  hold_cnt_d = '0;
               end
            end
            default: begin
               state_d    = RPT_IDLE;
               hold_cnt_d = '0;
            end
         endcase
      end

      // Repeat FSM outputs. A release accepted in the same cycle a repeat
      // falls due wins, so no repeat ever shares a cycle with a release.
      always_comb begin
         repeat_d = 1'b0;
         case (state_q)
            RPT_WAIT:   repeat_d = (hold_cnt_q == DELAY_LAST)  && !release_d;
            RPT_REPEAT: repeat_d = (hold_cnt_q == PERIOD_LAST) && !release_d;
            default:    repeat_d = 1'b0;
         endcase
         move_d = press_d | repeat_d;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
            move_q     <= 1'b0;
            state_q    <= RPT_IDLE;
            hold_cnt_q <= '0;
         end else begin
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
            move_q     <= move_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
         end
      end

      assign level_out[i]     = level_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign repeat_pulse[i]  = repeat_q;
      assign move_pulse[i]    = move_q;
   end

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Two instances share one stimulus: dut_a (all channels repeat, active-high
// inputs) and dut_b (repeat disabled on ch2, active-low inputs fed with the
// inverted stimulus). A window/arithmetic reference model predicts every
// output of both instances each cycle.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

   localparam int         N    = 5;
   localparam int         DB   = 4;
   localparam int         RD   = 10;
   localparam int         RP   = 3;
   localparam logic [4:0] EN_B = 5'b11011;

   logic       clk;
   logic       reset;
   logic [4:0] raw_in;
   logic [4:0] raw_n;
   logic [4:0] level_a, press_a, release_a, repeat_a, move_a;
   logic [4:0] level_b, press_b, release_b, repeat_b, move_b;

   assign raw_n = ~raw_in;

   input_debouncer #(
      .N_CH(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .REPEAT_EN(5'b11111), .ACTIVE_LOW_IN(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .level_out(level_a), .press_pulse(press_a), .release_pulse(release_a),
      .repeat_pulse(repeat_a), .move_pulse(move_a)
   );

   input_debouncer #(
      .N_CH(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .REPEAT_EN(EN_B), .ACTIVE_LOW_IN(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .raw_in(raw_n),
      .level_out(level_b), .press_pulse(press_b), .release_pulse(release_b),
      .repeat_pulse(repeat_b), .move_pulse(move_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [4:0] actual, input logic [4:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[k] = raw sample taken k edges ago (hist[0] = this edge).
   logic [4:0] hist[$];
   logic [4:0] lvl_m, e_press, e_rel, e_rep;
   int         press_t[N];
   int         edge_n = 0;

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < DB + 2; k++) hist.push_front(5'b0);
      lvl_m   = '0;
      e_press = '0;
      e_rel   = '0;
      e_rep   = '0;
      for (int c = 0; c < N; c++) press_t[c] = 0;
   endtask

   task automatic model_edge(input logic [4:0] raw);
      bit all_diff;
      int d;
      edge_n++;
      hist.push_front(raw);
      void'(hist.pop_back());
      e_press = '0;
      e_rel   = '0;
      e_rep   = '0;
      for (int c = 0; c < N; c++) begin
         // Accept a change once DB consecutive synchronised samples (which
         // lag the raw samples by two edges) all disagree with the level.
         all_diff = 1'b1;
         for (int j = 2; j <= DB + 1; j++)
            if (hist[j][c] == lvl_m[c]) all_diff = 1'b0;
         if (all_diff) begin
            lvl_m[c] = ~lvl_m[c];
            if (lvl_m[c]) begin
               e_press[c] = 1'b1;
               press_t[c] = edge_n;
            end else begin
               e_rel[c] = 1'b1;
            end
         end
         if (lvl_m[c] && !e_press[c]) begin
            d = edge_n - press_t[c];
            if (d >= RD && ((d - RD) % RP) == 0) e_rep[c] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check("A.level",   level_a,   lvl_m);
      check("A.press",   press_a,   e_press);
      check("A.release", release_a, e_rel);
      check("A.repeat",  repeat_a,  e_rep);
      check("A.move",    move_a,    e_press | e_rep);
      check("B.level",   level_b,   lvl_m);
      check("B.press",   press_b,   e_press);
      check("B.release", release_b, e_rel);
      check("B.repeat",  repeat_b,  e_rep & EN_B);
      check("B.move",    move_b,    e_press | (e_rep & EN_B));
   endtask

   // Drive at the falling edge, clock once, compare at the next falling edge.
   task automatic step(input logic [4:0] raw);
      raw_in = raw;
      @(posedge clk);
      model_edge(raw);
      @(negedge clk);
      compare_all();
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
   task automatic pulse_reset();
      #2;
      reset = 1'b0;
      #1;
      check("rst.level",   level_a   | level_b,   5'b0);
      check("rst.press",   press_a   | press_b,   5'b0);
      check("rst.release", release_a | release_b, 5'b0);
      check("rst.repeat",  repeat_a  | repeat_b,  5'b0);
      check("rst.move",    move_a    | move_b,    5'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) step(5'b0);
   endtask

   typedef struct {
      logic [4:0] raw;
      logic [4:0] level;
      logic [4:0] press;
      logic [4:0] rel;
   } vec_t;

   vec_t       tbl[14];
   int         cnt, idx, cnt_b;
   logic [4:0] cur;

   initial begin
      // Clean ch0 press driven after edge 0: level/press at edge 6, then
      // release driven after edge 8: release at edge 14.
      for (int r = 0; r < 14; r++) begin
         tbl[r].raw   = (r < 8) ? 5'b00001 : 5'b00000;
         tbl[r].level = (r >= 5 && r < 13) ? 5'b00001 : 5'b00000;
         tbl[r].press = (r == 5) ? 5'b00001 : 5'b00000;
         tbl[r].rel   = (r == 13) ? 5'b00001 : 5'b00000;
      end

      raw_in = 5'b0;
      reset  = 1'b0;
      model_reset();
      #3;
      check("init.level", level_a | level_b, 5'b0);
      check("init.press", press_a | press_b | move_a | move_b, 5'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      settle(3);

      // ---- table-driven clean press/release on ch0 ----
      for (int r = 0; r < 14; r++) begin
         step(tbl[r].raw);
         check($sformatf("tbl%0d.level", r), level_a,   tbl[r].level);
         check($sformatf("tbl%0d.press", r), press_a,   tbl[r].press);
         check($sformatf("tbl%0d.move", r),  move_a,    tbl[r].press);
         check($sformatf("tbl%0d.rel", r),   release_a, tbl[r].rel);
      end
      settle(4);

      // ---- ch1 bounce 1,0,1,0 (2 cycles each) then stable ----
      cnt = 0; idx = -1;
      for (int i = 0; i < 20; i++) begin
         step((i >= 8 || (i % 4) < 2) ? 5'b00010 : 5'b00000);
         if (press_a[1]) begin
            cnt++;
            idx = i;
         end
      end
      check("bounce.npress", 5'(cnt), 5'd1);
      check("bounce.at",     5'(idx), 5'd13);
      settle(12);

      // ---- ch2 held: repeats at press+10,+13,...,+28, none on dut_b ----
      cnt = 0; cnt_b = 0; idx = -1;
      for (int i = 0; i < 60; i++) begin
         step((i < 36) ? 5'b00100 : 5'b00000);
         if (i == 5) check("hold.press", press_a, 5'b00100);
         if (i >= 6 && i <= 35 && repeat_a[2]) cnt++;
         if (repeat_b[2]) cnt_b++;
         if (release_a[2]) idx = i;
         if (i > 41 && repeat_a[2]) cnt = 99;
      end
      check("hold.nrepeat",  5'(cnt),   5'd7);
      check("hold.b_repeat", 5'(cnt_b), 5'd0);
      check("hold.rel_at",   6'(idx),   6'd41);
      settle(4);

      // ---- release lands exactly when the first repeat is due ----
      for (int i = 0; i < 20; i++) begin
         step((i < 10) ? 5'b00100 : 5'b00000);
         if (i == 15) begin
            check("due.release", release_a & 5'b00100, 5'b00100);
            check("due.repeat",  repeat_a,             5'b00000);
         end
      end
      settle(4);

      // ---- simultaneous presses on ch0 and ch4 ----
      for (int i = 0; i < 8; i++) begin
         step(5'b10001);
         if (i == 5) begin
            check("simul.press_a", press_a, 5'b10001);
            check("simul.press_b", press_b, 5'b10001);
         end
      end
      settle(10);

      // ---- reset during ch3 WAIT_DELAY, ch3 still held ----
      for (int i = 0; i < 9; i++) step(5'b01000);
      pulse_reset();
      cnt = 0; idx = -1;
      for (int i = 0; i < 15; i++) begin
         step(5'b01000);
         if (press_a[3]) begin
            cnt++;
            idx = i + 1;
         end
      end
      check("rst3.npress", 5'(cnt), 5'd1);
      check("rst3.edge",   5'(idx), 5'd6);
      settle(10);

      // ---- randomized: glitchy phase, then long holds, reset in between ----
      cur = 5'b0;
      for (int i = 0; i < 1600; i++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, (i < 800) ? 5 : 29) == 0) cur[c] = ~cur[c];
         step(cur);
         if (i == 800) pulse_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
